// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the sequence-detect scheduler.
//   state_t      : scheduler FSM states
//   DEF_PAT_W    : default pattern length
//   DEF_PATTERN  : default pattern, leftmost bit received first
//   cnt_width()  : bits needed to hold the values 0..n
package seq_detect_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    FLUSH,
    DONE
  } state_t;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_detect_core.sv
// Serial Moore pattern detector.
//   clock, reset  : clock, async active-low reset
//   clr           : synchronous clear of history and fill count
//   bit_in        : serial data bit
//   bit_valid     : bit_in is sampled on this edge
//   detector_out  : high while the last PAT_W sampled bits equal PATTERN
module seq_detect_core
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic bit_in,
  input  logic bit_valid,
  output logic detector_out
);

  localparam int FILL_W = cnt_width(PAT_W);

  logic [PAT_W-1:0]  history;
  logic [FILL_W-1:0] fill;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      history <= '0;
      fill    <= '0;
    end else if (clr) begin
      history <= '0;
      fill    <= '0;
    end else if (bit_valid) begin
      // Newest bit enters at the LSB; the cast drops the oldest bit.
      history <= PAT_W'({history, bit_in});
      if (fill != FILL_W'(PAT_W)) fill <= fill + 1'b1;
    end
  end

  // Moore output: decoded from registered state only. The fill guard keeps
  // cleared history from matching a pattern of all zeros.
  assign detector_out = (history == PATTERN) && (fill >= FILL_W'(PAT_W));

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one serial pattern detector among requesters.
//   clock, reset  : clock, async active-low reset
//   req           : per-requester request level
//   word_in       : requester i word at [i*WORD_W +: WORD_W]
//   grant         : one-hot pulse in the LOAD cycle for the accepted requester
//   busy          : high in every state except IDLE
//   serial_bit    : bit currently presented to the detector
//   detector_out  : detector Moore output
//   done          : one-cycle result-valid pulse
//   done_id       : index of the serviced requester
//   match_cnt     : overlapping matches found in the serviced word
module seq_detect_scheduler
  import seq_detect_pkg::*;
#(
  parameter int               NUM_REQ = 4,
  parameter int               WORD_W  = 16,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  localparam int              ID_W    = $clog2(NUM_REQ),
  localparam int              CNT_W   = cnt_width(WORD_W)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*WORD_W-1:0] word_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      serial_bit,
  output logic                      detector_out,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [CNT_W-1:0]          match_cnt
);

  state_t            state;
  logic [WORD_W-1:0] shift_reg;
  logic [ID_W-1:0]   cur_id;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              win_valid;
  logic [ID_W-1:0]   win_id;

  // Round-robin search from rr_ptr+1 upward with wrap. Walking the offsets
  // downward lets the nearest requester overwrite any farther one.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        win_valid = 1'b1;
        win_id    = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Count detector hits, saturating at WORD_W.
  assign cnt_next = (detector_out && (cnt != CNT_W'(WORD_W))) ? cnt + 1'b1 : cnt;

  assign busy       = (state != IDLE);
  assign serial_bit = (state == SHIFT) && shift_reg[WORD_W-1];

  seq_detect_core #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_core (
    .clock        (clock),
    .reset        (reset),
    .clr          (state == LOAD),
    .bit_in       (serial_bit),
    .bit_valid    (state == SHIFT),
    .detector_out (detector_out)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      cur_id    <= '0;
      rr_ptr    <= ID_W'(NUM_REQ - 1);  // req[0] has first priority
      bit_cnt   <= '0;
      cnt       <= '0;
      grant     <= '0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
    end else begin
      grant <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            shift_reg <= word_in[win_id*WORD_W +: WORD_W];
            cur_id    <= win_id;
            rr_ptr    <= win_id;
            grant     <= NUM_REQ'(1) << win_id;  // visible during LOAD
            state     <= LOAD;
          end
        end
        LOAD: begin
          cnt     <= '0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          shift_reg <= shift_reg << 1;
          cnt       <= cnt_next;
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(WORD_W - 1)) state <= FLUSH;
        end
        FLUSH: begin
          // The last bit's match is visible only now; fold it into the result.
          cnt       <= cnt_next;
          match_cnt <= cnt_next;
          done_id   <= cur_id;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Self-checking bench for seq_detect_scheduler: directed cases plus random
// request/word traffic against a sliding-window match model and a
// round-robin winner model.
module tb_seq_detect_scheduler;

  localparam int         NUM_REQ = 4;
  localparam int         WORD_W  = 16;
  localparam int         PAT_W   = 4;
  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int         ID_W    = 2;
  localparam int         CNT_W   = 5;

  logic                      clock = 1'b0;
  logic                      reset = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*WORD_W-1:0] word_in = '0;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic                      serial_bit;
  logic                      detector_out;
  logic                      done;
  logic [ID_W-1:0]           done_id;
  logic [CNT_W-1:0]          match_cnt;

  int                n_checks = 0;
  int                n_fail   = 0;
  int                rr_ptr   = NUM_REQ - 1;
  logic [WORD_W-1:0] words [NUM_REQ];

  always #5 clock = ~clock;

  seq_detect_scheduler #(
    .NUM_REQ (NUM_REQ),
    .WORD_W  (WORD_W),
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .word_in      (word_in),
    .grant        (grant),
    .busy         (busy),
    .serial_bit   (serial_bit),
    .detector_out (detector_out),
    .done         (done),
    .done_id      (done_id),
    .match_cnt    (match_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // True when the first k bits received (MSB first) end with PATTERN.
  function automatic bit ends_match(input logic [WORD_W-1:0] w, input int k);
    logic [WORD_W-1:0] t;
    if (k < PAT_W) return 1'b0;
    t = w >> (WORD_W - k);
    return t[PAT_W-1:0] == PATTERN;
  endfunction

  function automatic int count_matches(input logic [WORD_W-1:0] w);
    int n = 0;
    for (int k = PAT_W; k <= WORD_W; k++) if (ends_match(w, k)) n++;
    return n;
  endfunction

  function automatic int pick_winner(input logic [NUM_REQ-1:0] r);
    for (int k = 1; k <= NUM_REQ; k++)
      if (r[(rr_ptr + k) % NUM_REQ]) return (rr_ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic set_word(input int i, input logic [WORD_W-1:0] w);
    words[i] = w;
    word_in[i*WORD_W +: WORD_W] = w;
  endtask

  // Wait for a grant, follow the job to done, and check every cycle of it.
  task automatic run_job(input int exp_id, input int exp_cnt, input bit drop_req);
    logic [WORD_W-1:0] w;
    int                n;
    bit                got;
    w   = words[exp_id];
    got = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clock);
      if (grant != '0) begin
        got = 1'b1;
        break;
      end
    end
    check("grant_seen", 32'(got), 32'd1);
    if (!got) return;
    check("grant_onehot", 32'(grant), 32'(1) << exp_id);
    check("busy_load", 32'(busy), 32'd1);
    rr_ptr = exp_id;
    if (drop_req) req[exp_id] = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (done) break;
      check("busy_job", 32'(busy), 32'd1);
      check("grant_pulse", 32'(grant), 32'd0);
      if (n <= WORD_W) check("serial_bit", 32'(serial_bit), 32'(w[WORD_W-n]));
      if (n <= WORD_W + 1) check("detector_out", 32'(detector_out), 32'(ends_match(w, n - 1)));
    end
    check("done_seen", 32'(done), 32'd1);
    if (!done) return;
    check("latency", 32'(n), 32'(WORD_W + 2));
    check("done_id", 32'(done_id), 32'(exp_id));
    check("match_cnt", 32'(match_cnt), 32'(exp_cnt));
    check("grant_vs_done", 32'(grant), 32'd0);
    @(negedge clock);
    check("done_width", 32'(done), 32'd0);
    check("match_cnt_hold", 32'(match_cnt), 32'(exp_cnt));
  endtask

  function automatic logic [WORD_W-1:0] rand_word();
    logic [WORD_W-1:0] w;
    case ($urandom_range(0, 2))
      0:       w = WORD_W'($urandom);
      1:       w = 16'hBBBB ^ (WORD_W'(1) << $urandom_range(0, WORD_W - 1));
      default: w = WORD_W'($urandom) | 16'hB6DB;
    endcase
    return w;
  endfunction

  initial begin
    int ids [5] = '{0, 1, 2, 3, 0};
    int exp_id;
    bit got;

    // Reset asserted with req[0] high: everything quiet, no grant.
    #12 reset = 1'b1;
    #15;
    set_word(0, 16'hB6DB);
    req = 4'b0001;
    #3 reset = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_match_cnt", 32'(match_cnt), 32'd0);
    check("rst_serial", 32'(serial_bit), 32'd0);
    check("rst_detector", 32'(detector_out), 32'd0);
    repeat (2) begin
      @(negedge clock);
      check("rst_hold_grant", 32'(grant), 32'd0);
      check("rst_hold_busy", 32'(busy), 32'd0);
    end
    #2 reset = 1'b1;
    rr_ptr = NUM_REQ - 1;
    run_job(0, 5, 1'b1);

    // Directed words.
    set_word(2, 16'h000B); req = 4'b0100; run_job(2, 1, 1'b1);
    set_word(1, 16'hFFFF); req = 4'b0010; run_job(1, 0, 1'b1);
    set_word(1, 16'hB000); req = 4'b0010; run_job(1, 1, 1'b1);

    // Reset in the middle of SHIFT aborts the job.
    set_word(3, 16'hB6DB);
    req = 4'b1000;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (grant != '0) begin
        got = 1'b1;
        break;
      end
    end
    check("abort_grant", 32'(grant), 32'h8);
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_match_cnt", 32'(match_cnt), 32'd0);
    check("abort_serial", 32'(serial_bit), 32'd0);
    check("abort_detector", 32'(detector_out), 32'd0);
    req    = '0;
    rr_ptr = NUM_REQ - 1;
    @(negedge clock);
    reset = 1'b1;
    repeat (25) begin
      @(negedge clock);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    req = 4'b1000;
    run_job(3, 5, 1'b1);

    // All four requesting continuously: strict rotation.
    for (int i = 0; i < NUM_REQ; i++) set_word(i, 16'hB6DB);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) run_job(ids[j], 5, 1'b0);
    req = '0;

    // Random traffic against the model.
    for (int it = 0; it < 30; it++) begin
      logic [NUM_REQ-1:0] add;
      add = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (add[i] && !req[i]) begin
          set_word(i, rand_word());
          req[i] = 1'b1;
        end
      end
      if (req == '0) begin
        exp_id = $urandom_range(0, NUM_REQ - 1);
        set_word(exp_id, rand_word());
        req[exp_id] = 1'b1;
      end
      exp_id = pick_winner(req);
      run_job(exp_id, count_matches(words[exp_id]), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
- Shares one serial Moore pattern detector among NUM_REQ requesters.
- Each requester presents a parallel word. A round-robin arbiter grants one requester, and the controller shifts that word MSB-first through the detector.
- Overlapping pattern matches are counted, and the count is returned with the winner's id and a one-cycle done pulse.
- The block sits between the parallel word sources and the serial detector datapath.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WORD_W, 16, bits per request word.
- PAT_W, 4, pattern length in bits (<= WORD_W).
- PATTERN, 4'b1011, pattern to detect; its leftmost bit is the first bit received.
- Derived localparams: ID_W = $clog2(NUM_REQ); CNT_W = $clog2(WORD_W+1).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req  in  NUM_REQ  per-requester request level.
- word_in  in  NUM_REQ*WORD_W  requester i word at bits [i*WORD_W +: WORD_W].
- grant  out  NUM_REQ  one-hot, one-cycle pulse marking the accepted requester.
- busy  out  1  high in every state except IDLE.
- serial_bit  out  1  bit currently driven into the detector (observation).
- detector_out  out  1  detector Moore output (observation).
- done  out  1  one-cycle pulse: result valid.
- done_id  out  ID_W  index of the serviced requester.
- match_cnt  out  CNT_W  number of matches in the serviced word.

Behaviour:
- Reset (reset==0, asynchronous):
  - State = IDLE.
  - grant, done, done_id, match_cnt, serial_bit, detector_out = 0.
  - Shift register, bit counter and internal count = 0.
  - Round-robin pointer = NUM_REQ-1, so req[0] has first priority.
  - Detector history cleared.
  - Reset mid-operation aborts the job: no done pulse, and the requester must re-request.
- FSM states: IDLE, LOAD, SHIFT, FLUSH, DONE.
- IDLE:
  - If any req bit is high, pick the winner by searching from pointer+1 upward with wrap.
  - On that edge: capture the winner's word into the shift register, record the winner id, update pointer to the winner, go to LOAD.
  - If req is all zero, stay in IDLE.
- LOAD (1 cycle):
  - grant[id] = 1.
  - Detector history and the internal count are cleared synchronously.
  - Next state: SHIFT. Bit counter = 0.
- SHIFT (exactly WORD_W cycles):
  - serial_bit = shift-register MSB.
  - At each edge: the detector samples serial_bit, the shift register shifts left, the bit counter increments.
  - After WORD_W cycles, go to FLUSH.
- FLUSH (1 cycle): lets the final bit's detection appear on the Moore output.
- Counting:
  - In SHIFT and FLUSH, the internal count increments at the edge whenever detector_out==1.
  - The count saturates at WORD_W; saturation is never reached for legal PAT_W.
- DONE (1 cycle):
  - done = 1; match_cnt and done_id are registered on entry to DONE.
  - match_cnt and done_id hold until the next DONE.
  - Next state: IDLE.
- Latency:
  - done rises WORD_W+2 cycles after the grant cycle: 18 cycles at defaults.
  - The next grant is at earliest 2 cycles after done.
- Requests while busy are ignored; no queuing.
- req deassertion after the capture edge has no effect.
- The requester must hold req and word stable until grant.
- Detector:
  - Moore machine with a PAT_W-bit history plus a saturating fill counter.
  - detector_out = (history==PATTERN) && (fill>=PAT_W). It depends only on registered state.
  - Overlapping matches count, e.g. 1011011 yields 2 matches.
- grant and done are never high in the same cycle.

Decomposition:
- Package seq_detect_pkg:
  - State enum (IDLE, LOAD, SHIFT, FLUSH, DONE).
  - Default PATTERN and PAT_W constants.
  - A clog2-based width helper.
- Sub-module seq_detect_core (params PAT_W, PATTERN):
  - Ports: clock, reset, clr, bit_in, bit_valid, detector_out.
  - The scheduler instantiates it once.
- The round-robin arbiter stays inline.

Test Plan:
- Reset asserted at 30 ns while req[0] is high → all outputs 0, no grant; the first grant follows release.
- req[0]=1, word 16'hB6DB → grant=4'b0001 for 1 cycle; done 18 cycles later; match_cnt=5, done_id=0.
- req[2]=1, word 16'h000B → match_cnt=1 (final match is caught only in FLUSH).
- req[1]=1, word 16'hFFFF → match_cnt=0.
- req[1]=1, word 16'hB000 → match_cnt=1.
- req=4'b1111 held continuously, all words 16'hB6DB → grants in order 0,1,2,3,0; each done carries match_cnt=5; busy high throughout each job.
- Pull reset low during SHIFT of a job → immediate return to IDLE with count cleared; no done pulse; a re-request completes normally.
